// File: rtl/func_gen_multi.sv
// Multi-channel function generator.
// Each channel divides the clock, steps a phase accumulator on every divider
// tick and turns the phase into one of eight waveforms with a selectable
// amplitude shift. New settings are staged in a pending register and take
// effect at a phase wrap, on sync, or at once while the channel is disabled.
module func_gen_multi #(
  parameter int CHANNELS = 2,
  parameter int DATA_W   = 8,
  parameter int DIV_W    = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [CHANNELS-1:0]        enable,
  input  logic                       sync,
  input  logic                       cfg_we,
  input  logic [2:0]                 cfg_ch,
  input  logic [DIV_W-1:0]           cfg_div,
  input  logic [2:0]                 cfg_func,
  input  logic [1:0]                 cfg_amp,
  input  logic [DATA_W-1:0]          cfg_phase,
  output logic [CHANNELS*DATA_W-1:0] out,
  output logic [CHANNELS-1:0]        sample_stb
);

  localparam logic [DATA_W-1:0] MAX_V      = {DATA_W{1'b1}};
  localparam logic [DATA_W-1:0] MID_V      = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] STAIR_MASK = ~DATA_W'(15);

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      // active configuration
      logic [DIV_W-1:0]  div_reg;
      logic [2:0]        func_reg;
      logic [1:0]        amp_reg;
      logic [DATA_W-1:0] off_reg;
      // staged configuration waiting for its apply point
      logic [DIV_W-1:0]  pdiv_reg;
      logic [2:0]        pfunc_reg;
      logic [1:0]        pamp_reg;
      logic [DATA_W-1:0] poff_reg;
      logic              pv_reg, pv_next;
      // running state
      logic [DIV_W-1:0]  cnt_reg, cnt_next;
      logic [DATA_W-1:0] phase_reg, phase_next;
      logic              chg_reg, chg_next;
      logic [DATA_W-1:0] out_reg;
      logic              stb_reg;
      // decode
      logic              en;
      logic              wr_hit;
      logic              tick;
      logic              wrap;
      logic              apply_cfg;
      logic [DATA_W-1:0] dbl;
      logic [DATA_W-1:0] wave;
      logic [DATA_W-1:0] scaled;

      assign en     = enable[gi];
      assign wr_hit = cfg_we && (int'(cfg_ch) == gi);
      // >= rather than == so a counter frozen above a newly shrunk divider still ticks
      assign tick   = en && (cnt_reg >= div_reg);
      assign wrap   = tick && (phase_reg == MAX_V);
      assign dbl    = {phase_reg[DATA_W-2:0], 1'b0};

      // waveform lookup from the current phase, then amplitude shift
      always_comb begin
        wave = '0;
        case (func_reg)
          3'b000: wave = phase_reg;
          3'b001: wave = MAX_V - phase_reg;
          3'b010: wave = phase_reg[DATA_W-1] ? (MAX_V - dbl) : dbl;
          3'b011: wave = phase_reg[DATA_W-1] ? '0 : MAX_V;
          3'b100: wave = (phase_reg[DATA_W-1:DATA_W-2] == 2'b00) ? MAX_V : '0;
          3'b101: wave = phase_reg & STAIR_MASK;
          3'b110: wave = MID_V;
          default: wave = '0;
        endcase
        scaled = wave >> (2'd3 - amp_reg);
      end

      // divider, phase and pending-config sequencing; sync overrides ticking
      always_comb begin
        apply_cfg  = 1'b0;
        cnt_next   = cnt_reg;
        phase_next = phase_reg;
        chg_next   = 1'b0;
        if (sync) begin
          apply_cfg  = pv_reg;
          cnt_next   = '0;
          phase_next = pv_reg ? poff_reg : off_reg;
          chg_next   = en;
        end else if (en) begin
          if (tick) begin
            cnt_next   = '0;
            chg_next   = 1'b1;
            apply_cfg  = wrap && pv_reg;
            phase_next = (wrap && pv_reg) ? poff_reg : phase_reg + 1'b1;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end else if (pv_reg) begin
          // idle channel: nothing to wait for, adopt the staged settings now
          apply_cfg  = 1'b1;
          phase_next = poff_reg;
        end
        // a write landing on an apply edge is kept for the next apply point
        pv_next = wr_hit ? 1'b1 : (apply_cfg ? 1'b0 : pv_reg);
      end

      // state registers; the output stage trails the phase change by one clock
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          div_reg   <= '0;
          func_reg  <= 3'b111;
          amp_reg   <= 2'b11;
          off_reg   <= '0;
          pdiv_reg  <= '0;
          pfunc_reg <= 3'b111;
          pamp_reg  <= 2'b11;
          poff_reg  <= '0;
          pv_reg    <= 1'b0;
          cnt_reg   <= '0;
          phase_reg <= '0;
          chg_reg   <= 1'b0;
          out_reg   <= '0;
          stb_reg   <= 1'b0;
        end else begin
          cnt_reg   <= cnt_next;
          phase_reg <= phase_next;
          chg_reg   <= chg_next;
          pv_reg    <= pv_next;
          if (apply_cfg) begin
            div_reg  <= pdiv_reg;
            func_reg <= pfunc_reg;
            amp_reg  <= pamp_reg;
            off_reg  <= poff_reg;
          end
          if (wr_hit) begin
            pdiv_reg  <= cfg_div;
            pfunc_reg <= cfg_func;
            pamp_reg  <= cfg_amp;
            poff_reg  <= cfg_phase;
          end
          if (chg_reg && en) begin
            out_reg <= scaled;
            stb_reg <= 1'b1;
          end else begin
            stb_reg <= 1'b0;
          end
        end
      end

      assign out[gi*DATA_W +: DATA_W] = out_reg;
      assign sample_stb[gi]           = stb_reg;
    end
  endgenerate

endmodule
